// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels of both requesters plus the
// shared-ALU operand/result bus, grouped for the alu_arbiter port list.
// slave  = arbiter side, master = requester/ALU side.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
);
    // requester 0
    logic              i_req0_valid;
    logic [DATA_W-1:0] i_req0_op1;
    logic [DATA_W-1:0] i_req0_op2;
    logic [CTRL_W-1:0] i_req0_control;
    logic              o_req0_ready;
    logic              o_rsp0_valid;
    logic [DATA_W-1:0] o_rsp0_result;
    logic              o_rsp0_overflow;
    logic              o_rsp0_zf;
    logic              i_rsp0_ready;

    // requester 1
    logic              i_req1_valid;
    logic [DATA_W-1:0] i_req1_op1;
    logic [DATA_W-1:0] i_req1_op2;
    logic [CTRL_W-1:0] i_req1_control;
    logic              o_req1_ready;
    logic              o_rsp1_valid;
    logic [DATA_W-1:0] o_rsp1_result;
    logic              o_rsp1_overflow;
    logic              o_rsp1_zf;
    logic              i_rsp1_ready;

    // shared combinational ALU
    logic [DATA_W-1:0] o_alu_op1;
    logic [DATA_W-1:0] o_alu_op2;
    logic [CTRL_W-1:0] o_alu_control;
    logic [DATA_W-1:0] i_alu_result;
    logic              i_alu_overflow;
    logic              i_alu_zf;

    modport slave (
        input  i_req0_valid, i_req0_op1, i_req0_op2, i_req0_control,
        output o_req0_ready,
        output o_rsp0_valid, o_rsp0_result, o_rsp0_overflow, o_rsp0_zf,
        input  i_rsp0_ready,
        input  i_req1_valid, i_req1_op1, i_req1_op2, i_req1_control,
        output o_req1_ready,
        output o_rsp1_valid, o_rsp1_result, o_rsp1_overflow, o_rsp1_zf,
        input  i_rsp1_ready,
        output o_alu_op1, o_alu_op2, o_alu_control,
        input  i_alu_result, i_alu_overflow, i_alu_zf
    );

    modport master (
        output i_req0_valid, i_req0_op1, i_req0_op2, i_req0_control,
        input  o_req0_ready,
        input  o_rsp0_valid, o_rsp0_result, o_rsp0_overflow, o_rsp0_zf,
        output i_rsp0_ready,
        output i_req1_valid, i_req1_op1, i_req1_op2, i_req1_control,
        input  o_req1_ready,
        input  o_rsp1_valid, o_rsp1_result, o_rsp1_overflow, o_rsp1_zf,
        output i_rsp1_ready,
        input  o_alu_op1, o_alu_op2, o_alu_control,
        output i_alu_result, i_alu_overflow, i_alu_zf
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Grant is combinational (one per cycle); the ALU result/flags are captured
// into a per-requester response slot on the edge closing the grant cycle.
// Each slot is an EMPTY/FULL machine so a stalled response on one side never
// blocks the other side.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins ties); default build uses round-robin via last_grant.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
) (
    input logic          i_clk,
    input logic          i_rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e       slot0_q, slot0_d;
    slot_state_e       slot1_q, slot1_d;

    logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
    logic              rsp0_overflow_q, rsp0_overflow_d;
    logic              rsp0_zf_q, rsp0_zf_d;
    logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
    logic              rsp1_overflow_q, rsp1_overflow_d;
    logic              rsp1_zf_q, rsp1_zf_d;

    logic              elig0, elig1;
    logic              grant0, grant1;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // 0/1 = requester granted most recently; reset to 1 so requester 0 wins first
    logic              last_grant_q, last_grant_d;
`endif

    // A requester may be accepted when its slot is free or is being drained now
    always_comb begin
        elig0 = bus.i_req0_valid & ((slot0_q == SLOT_EMPTY) | bus.i_rsp0_ready);
        elig1 = bus.i_req1_valid & ((slot1_q == SLOT_EMPTY) | bus.i_rsp1_ready);
    end

    // Pick at most one requester per cycle
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant0 = elig0;
        grant1 = elig1 & ~elig0;
`else
        // on a tie, the requester that did not win last time goes first
        grant0 = elig0 & (~elig1 | last_grant_q);
        grant1 = elig1 & (~elig0 | ~last_grant_q);
`endif
    end

    // Steer the granted requester's operands onto the ALU; idle bus is all-zero
    always_comb begin
        bus.o_alu_op1     = '0;
        bus.o_alu_op2     = '0;
        bus.o_alu_control = '0;
        if (grant0) begin
            bus.o_alu_op1     = bus.i_req0_op1;
            bus.o_alu_op2     = bus.i_req0_op2;
            bus.o_alu_control = bus.i_req0_control;
        end else if (grant1) begin
            bus.o_alu_op1     = bus.i_req1_op1;
            bus.o_alu_op2     = bus.i_req1_op2;
            bus.o_alu_control = bus.i_req1_control;
        end
    end

    // Handshake and response outputs
    always_comb begin
        bus.o_req0_ready    = grant0;
        bus.o_req1_ready    = grant1;
        bus.o_rsp0_valid    = (slot0_q == SLOT_FULL);
        bus.o_rsp0_result   = rsp0_result_q;
        bus.o_rsp0_overflow = rsp0_overflow_q;
        bus.o_rsp0_zf       = rsp0_zf_q;
        bus.o_rsp1_valid    = (slot1_q == SLOT_FULL);
        bus.o_rsp1_result   = rsp1_result_q;
        bus.o_rsp1_overflow = rsp1_overflow_q;
        bus.o_rsp1_zf       = rsp1_zf_q;
    end

    // Response slot 0: fill on grant, drain on consume, otherwise hold
    always_comb begin
        slot0_d         = slot0_q;
        rsp0_result_d   = rsp0_result_q;
        rsp0_overflow_d = rsp0_overflow_q;
        rsp0_zf_d       = rsp0_zf_q;
        if (grant0) begin
            slot0_d         = SLOT_FULL;
            rsp0_result_d   = bus.i_alu_result;
            rsp0_overflow_d = bus.i_alu_overflow;
            rsp0_zf_d       = bus.i_alu_zf;
        end else if (bus.i_rsp0_ready) begin
            slot0_d = SLOT_EMPTY;
        end
    end

    // Response slot 1: fill on grant, drain on consume, otherwise hold
    always_comb begin
        slot1_d         = slot1_q;
        rsp1_result_d   = rsp1_result_q;
        rsp1_overflow_d = rsp1_overflow_q;
        rsp1_zf_d       = rsp1_zf_q;
        if (grant1) begin
            slot1_d         = SLOT_FULL;
            rsp1_result_d   = bus.i_alu_result;
            rsp1_overflow_d = bus.i_alu_overflow;
            rsp1_zf_d       = bus.i_alu_zf;
        end else if (bus.i_rsp1_ready) begin
            slot1_d = SLOT_EMPTY;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves only when someone is granted
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Slot state and captured data; reset drops any pending or in-flight result
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot0_q         <= SLOT_EMPTY;
            slot1_q         <= SLOT_EMPTY;
            rsp0_result_q   <= '0;
            rsp0_overflow_q <= 1'b0;
            rsp0_zf_q       <= 1'b0;
            rsp1_result_q   <= '0;
            rsp1_overflow_q <= 1'b0;
            rsp1_zf_q       <= 1'b0;
        end else begin
            slot0_q         <= slot0_d;
            slot1_q         <= slot1_d;
            rsp0_result_q   <= rsp0_result_d;
            rsp0_overflow_q <= rsp0_overflow_d;
            rsp0_zf_q       <= rsp0_zf_d;
            rsp1_result_q   <= rsp1_result_d;
            rsp1_overflow_q <= rsp1_overflow_d;
            rsp1_zf_q       <= rsp1_zf_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus for alu_arbiter with a queue scoreboard.
// Stimulus pushes hand-computed responses; a negedge monitor pops and compares
// whenever a response is consumed (valid & ready).
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 6;

    localparam logic [CW-1:0] F_ADD = 6'b100000;
    localparam logic [CW-1:0] F_SUB = 6'b100010;
    localparam logic [CW-1:0] F_AND = 6'b100100;
    localparam logic [CW-1:0] F_OR  = 6'b100101;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          ovf;
        logic          zf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    logic [DW-1:0] alu_res;
    logic          alu_ovf;

    alu_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: ADD/SUB report unsigned carry/borrow as overflow
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.o_alu_control)
            F_ADD:   {alu_ovf, alu_res} = {1'b0, bus.o_alu_op1} + {1'b0, bus.o_alu_op2};
            F_SUB:   {alu_ovf, alu_res} = {1'b0, bus.o_alu_op1} - {1'b0, bus.o_alu_op2};
            F_AND:   alu_res = bus.o_alu_op1 & bus.o_alu_op2;
            F_OR:    alu_res = bus.o_alu_op1 | bus.o_alu_op2;
            default: ;
        endcase
    end
    assign bus.i_alu_result   = alu_res;
    assign bus.i_alu_overflow = alu_ovf;
    assign bus.i_alu_zf       = (alu_res == '0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.i_req0_valid   = v;
        bus.i_req0_control = c;
        bus.i_req0_op1     = a;
        bus.i_req0_op2     = b;
    endtask

    task automatic req1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.i_req1_valid   = v;
        bus.i_req1_control = c;
        bus.i_req1_op1     = a;
        bus.i_req1_op2     = b;
    endtask

    // Monitor: compare each consumed response against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_rsp0_valid && bus.i_rsp0_ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp0_unexpected: actual result=%0h required=no response", bus.o_rsp0_result);
                end else begin
                    e0 = q0.pop_front();
                    check("rsp0_result", 64'(bus.o_rsp0_result), 64'(e0.res));
                    check("rsp0_overflow", 64'(bus.o_rsp0_overflow), 64'(e0.ovf));
                    check("rsp0_zf", 64'(bus.o_rsp0_zf), 64'(e0.zf));
                end
            end
            if (bus.o_rsp1_valid && bus.i_rsp1_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp1_unexpected: actual result=%0h required=no response", bus.o_rsp1_result);
                end else begin
                    e1 = q1.pop_front();
                    check("rsp1_result", 64'(bus.o_rsp1_result), 64'(e1.res));
                    check("rsp1_overflow", 64'(bus.o_rsp1_overflow), 64'(e1.ovf));
                    check("rsp1_zf", 64'(bus.o_rsp1_zf), 64'(e1.zf));
                end
            end
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    // Directed stimulus
    initial begin
        logic [CW-1:0] ops1 [3];
        logic [DW-1:0] a1 [4];
        logic [DW-1:0] b1 [4];
        logic [CW-1:0] c1 [4];
        logic [DW-1:0] r1 [4];

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req0(1'b0, '0, '0, '0);
        req1(1'b0, '0, '0, '0);
        bus.i_rsp0_ready = 1'b1;
        bus.i_rsp1_ready = 1'b1;
        repeat (2) cyc();

        check("reset_rsp0_valid", 64'(bus.o_rsp0_valid), 64'd0);
        check("reset_rsp1_valid", 64'(bus.o_rsp1_valid), 64'd0);
        check("reset_rsp0_result", 64'(bus.o_rsp0_result), 64'd0);
        check("reset_rsp1_result", 64'(bus.o_rsp1_result), 64'd0);
        check("idle_alu_op1", 64'(bus.o_alu_op1), 64'd0);

        // Single ADD 5 + 7
        rst_n = 1'b1;
        req0(1'b1, F_ADD, 32'd5, 32'd7);
        #1;
        check("add_req0_ready", 64'(bus.o_req0_ready), 64'd1);
        check("add_alu_op1", 64'(bus.o_alu_op1), 64'd5);
        check("add_alu_control", 64'(bus.o_alu_control), 64'(F_ADD));
        q0.push_back('{res: 32'd12, ovf: 1'b0, zf: 1'b0});
        cyc();
        req0(1'b0, '0, '0, '0);
        #1;
        check("add_rsp0_valid_lat1", 64'(bus.o_rsp0_valid), 64'd1);
        cyc();

        // Both requesters valid on the first cycle after reset
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req0(1'b1, F_SUB, 32'd9, 32'd9);
        req1(1'b1, F_OR, 32'hF0, 32'h0F);
        #1;
        check("tie_c0_ready0", 64'(bus.o_req0_ready), 64'd1);
        check("tie_c0_ready1", 64'(bus.o_req1_ready), 64'd0);
        q0.push_back('{res: 32'd0, ovf: 1'b0, zf: 1'b1});
        cyc();
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) begin
            req0(1'b1, F_ADD, 32'd1, 32'd1);
            #1;
            check("prio_ready0", 64'(bus.o_req0_ready), 64'd1);
            check("prio_ready1_starved", 64'(bus.o_req1_ready), 64'd0);
            q0.push_back('{res: 32'd2, ovf: 1'b0, zf: 1'b0});
            cyc();
        end
        req0(1'b0, '0, '0, '0);
        #1;
        check("prio_ready1_alone", 64'(bus.o_req1_ready), 64'd1);
        q1.push_back('{res: 32'hFF, ovf: 1'b0, zf: 1'b0});
        cyc();
        req1(1'b0, '0, '0, '0);
`else
        req0(1'b1, F_ADD, 32'd1, 32'd1);
        #1;
        check("rr_c1_ready1", 64'(bus.o_req1_ready), 64'd1);
        check("rr_c1_ready0", 64'(bus.o_req0_ready), 64'd0);
        q1.push_back('{res: 32'hFF, ovf: 1'b0, zf: 1'b0});
        cyc();
        req1(1'b0, '0, '0, '0);
        #1;
        check("rr_c2_ready0", 64'(bus.o_req0_ready), 64'd1);
        q0.push_back('{res: 32'd2, ovf: 1'b0, zf: 1'b0});
        cyc();
        req0(1'b0, '0, '0, '0);
`endif
        cyc();

        // Wrap-around ADD: carry out, zero result
        req0(1'b1, F_ADD, 32'hFFFF_FFFF, 32'd1);
        #1;
        check("wrap_ready0", 64'(bus.o_req0_ready), 64'd1);
        q0.push_back('{res: 32'd0, ovf: 1'b1, zf: 1'b1});
        cyc();
        req0(1'b0, '0, '0, '0);
        cyc();

        // Backpressure on requester 0 while requester 1 keeps flowing
        bus.i_rsp0_ready = 1'b0;
        req0(1'b1, F_ADD, 32'd2, 32'd3);
        #1;
        check("bp_first_ready0", 64'(bus.o_req0_ready), 64'd1);
        q0.push_back('{res: 32'd5, ovf: 1'b0, zf: 1'b0});
        cyc();
        ops1[0] = F_OR;
        ops1[1] = F_AND;
        ops1[2] = F_ADD;
        a1[0] = 32'd1;   b1[0] = 32'd2;   r1[0] = 32'd3;
        a1[1] = 32'hFF;  b1[1] = 32'h0F;  r1[1] = 32'h0F;
        a1[2] = 32'd100; b1[2] = 32'd200; r1[2] = 32'd300;
        for (int k = 0; k < 3; k++) begin
            req0(1'b1, F_ADD, 32'd10, 32'd20);
            req1(1'b1, ops1[k], a1[k], b1[k]);
            #1;
            check("bp_ready0_low", 64'(bus.o_req0_ready), 64'd0);
            check("bp_rsp0_valid_held", 64'(bus.o_rsp0_valid), 64'd1);
            check("bp_rsp0_result_held", 64'(bus.o_rsp0_result), 64'd5);
            check("bp_ready1_flows", 64'(bus.o_req1_ready), 64'd1);
            q1.push_back('{res: r1[k], ovf: 1'b0, zf: 1'b0});
            cyc();
        end
        req1(1'b0, '0, '0, '0);
        bus.i_rsp0_ready = 1'b1;
        #1;
        check("bp_release_ready0", 64'(bus.o_req0_ready), 64'd1);
        q0.push_back('{res: 32'd30, ovf: 1'b0, zf: 1'b0});
        cyc();
        req0(1'b0, '0, '0, '0);
        cyc();

        // Back-to-back on requester 1
        c1[0] = F_ADD; a1[0] = 32'd1;          b1[0] = 32'd2;     r1[0] = 32'd3;
        c1[1] = F_SUB; a1[1] = 32'd10;         b1[1] = 32'd3;     r1[1] = 32'd7;
        c1[2] = F_OR;  a1[2] = 32'h100;        b1[2] = 32'h001;   r1[2] = 32'h101;
        c1[3] = F_ADD; a1[3] = 32'h7FFF_FFFF;  b1[3] = 32'd1;     r1[3] = 32'h8000_0000;
        for (int k = 0; k < 4; k++) begin
            req1(1'b1, c1[k], a1[k], b1[k]);
            #1;
            check("b2b_ready1", 64'(bus.o_req1_ready), 64'd1);
            if (k > 0) check("b2b_rsp1_valid", 64'(bus.o_rsp1_valid), 64'd1);
            q1.push_back('{res: r1[k], ovf: 1'b0, zf: 1'b0});
            cyc();
        end
        req1(1'b0, '0, '0, '0);
        #1;
        check("b2b_rsp1_valid_last", 64'(bus.o_rsp1_valid), 64'd1);
        cyc();

        // Reset while rsp1 is pending and req0 is being granted
        bus.i_rsp1_ready = 1'b0;
        req1(1'b1, F_ADD, 32'd4, 32'd4);
        #1;
        check("rst_setup_ready1", 64'(bus.o_req1_ready), 64'd1);
        cyc();
        req1(1'b0, '0, '0, '0);
        req0(1'b1, F_ADD, 32'd1, 32'd1);
        #1;
        check("rst_setup_rsp1_valid", 64'(bus.o_rsp1_valid), 64'd1);
        check("rst_setup_ready0", 64'(bus.o_req0_ready), 64'd1);
        rst_n = 1'b0;
        cyc();
        check("rst_mid_rsp0_valid", 64'(bus.o_rsp0_valid), 64'd0);
        check("rst_mid_rsp1_valid", 64'(bus.o_rsp1_valid), 64'd0);
        rst_n = 1'b1;
        bus.i_rsp1_ready = 1'b1;
        req1(1'b1, F_ADD, 32'd4, 32'd4);
        #1;
        check("rst_after_ready0", 64'(bus.o_req0_ready), 64'd1);
        check("rst_after_ready1", 64'(bus.o_req1_ready), 64'd0);
        q0.push_back('{res: 32'd2, ovf: 1'b0, zf: 1'b0});
        cyc();
        req0(1'b0, '0, '0, '0);
        #1;
        check("rst_after_ready1_next", 64'(bus.o_req1_ready), 64'd1);
        q1.push_back('{res: 32'd8, ovf: 1'b0, zf: 1'b0});
        cyc();
        req1(1'b0, '0, '0, '0);

        // Let outstanding responses drain, bounded
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) cyc();
        cyc();
        check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
